// File: rtl/shift_seq_8_bit_if.sv
// Request/result bundle for shift_seq_8_bit: operand and control in, status and result out.
// The testbench drives the master side; the shifter implements the slave side.
interface shift_seq_8_bit_if;
  logic       start;
  logic [7:0] D;
  logic [2:0] count;
  logic       select;
  logic       ar_select;
  logic       fill_in;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] S;
  logic       carry;
  logic       sticky;

  modport master (
    output start, D, count, select, ar_select, fill_in,
    input  ready, busy, done, S, carry, sticky
  );

  modport slave (
    input  start, D, count, select, ar_select, fill_in,
    output ready, busy, done, S, carry, sticky
  );
endinterface

// File: rtl/shift_seq_8_bit.sv
// Sequential 8-bit shifter: one single-bit shift per clock, left, logical right or arithmetic right.
// Optional macro SHIFT_SEQ_STICKY_EN adds a sticky flag (OR of all bits shifted out).
module shift_seq_8_bit (
  input  logic              clk,
  input  logic              rst_n,
  shift_seq_8_bit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] s_q;
  logic [7:0] s_next;
  logic [2:0] cnt_q;
  logic       dir_q;
  logic       ar_q;
  logic       fill_q;
  logic       carry_q;
  logic       out_bit;
  logic       accept;

  assign accept = (state_q == IDLE) && bus.start;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = (bus.count != 3'd0) ? SHIFT : DONE;
      SHIFT:   if (cnt_q == 3'd1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One-step shift of the result register using the operation latched at accept.
  always_comb begin
    s_next  = s_q;
    out_bit = 1'b0;
    if (!dir_q) begin
      s_next  = {s_q[6:0], fill_q};
      out_bit = s_q[7];
    end else begin
      s_next  = {(ar_q ? s_q[7] : fill_q), s_q[7:1]};
      out_bit = s_q[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= 8'h00;
      cnt_q   <= 3'd0;
      dir_q   <= 1'b0;
      ar_q    <= 1'b0;
      fill_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      if (accept) begin
        s_q     <= bus.D;
        cnt_q   <= bus.count;
        dir_q   <= bus.select;
        ar_q    <= bus.ar_select;
        fill_q  <= bus.fill_in;
        carry_q <= 1'b0;
      end else if (state_q == SHIFT) begin
        s_q     <= s_next;
        cnt_q   <= cnt_q - 3'd1;
        carry_q <= out_bit;
      end
    end
  end

`ifdef SHIFT_SEQ_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               sticky_q <= 1'b0;
    else if (accept)                          sticky_q <= 1'b0;
    else if ((state_q == SHIFT) && out_bit)   sticky_q <= 1'b1;
  end

  assign bus.sticky = sticky_q;
`else
  assign bus.sticky = 1'b0;
`endif

  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q == SHIFT);
  assign bus.done  = (state_q == DONE);
  assign bus.S     = s_q;
  assign bus.carry = carry_q;

endmodule
